// File: rtl/sequence_generator.sv
// sequence_generator: parallel-in serial-out word shifter with ready/valid load and optional inter-word gap
module sequence_generator #(
  parameter int WIDTH = 8,
  parameter int GAP = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
  localparam int CW = (WIDTH > 256) ? $clog2(WIDTH) : 8;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic so_q, so_d, so_valid_q, so_valid_d, done_q, done_d;
  logic last_bit, accept;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
  assign load_ready = (state_q == ST_IDLE) || (GAP == 0 && last_bit);
  assign accept = load_valid && load_ready;
  assign busy = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign so = so_q;
  assign so_valid = so_valid_q;
  assign done = done_q;
  // next state: load on handshake, shift until the last bit, then gap or idle; illegal codes fall to idle
  always_comb begin
    state_d = ST_IDLE;
    cnt_d = '0;
    sr_d = sr_q;
    if (accept) begin
      state_d = ST_SHIFT;
      sr_d = data_in;
    end else if (state_q == ST_SHIFT && !last_bit) begin
      state_d = ST_SHIFT;
      cnt_d = cnt_q + 1'b1;
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end else if ((last_bit && GAP > 0) || (state_q == ST_GAP && cnt_q != LAST_GAP)) begin
      state_d = ST_GAP;
      cnt_d = (state_q == ST_GAP) ? cnt_q + 1'b1 : '0;
    end
    so_d = (state_d == ST_SHIFT) ? sr_d[WIDTH-1] : IDLE_LEVEL;
    so_valid_d = state_d == ST_SHIFT;
    done_d = (state_d == ST_SHIFT) && (cnt_d == LAST_BIT);
  end
  // state and registered serial outputs; reset aborts any word in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      so_q <= IDLE_LEVEL;
      so_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      so_q <= so_d;
      so_valid_q <= so_valid_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: scoreboard bench for the serializer, GAP=0 main instance plus a GAP=3 instance
module tb_sequence_generator;
  localparam int W = 8;
  typedef struct {int cyc; logic b; logic d;} exp_t;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0, g_valid = 1'b0;
  logic [7:0] data_in = '0, g_data = '0;
  logic load_ready, so, so_valid, busy, done;
  logic g_ready, g_so, g_so_valid, g_busy, g_done;
  int cyc = 0, tests = 0, fails = 0, next_ok = 0, det_cnt = 0;
  logic [2:0] hist = '0;
  exp_t sbq[$];
  bit busy_at[int];

  sequence_generator #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .so(so), .so_valid(so_valid), .busy(busy), .done(done));

  sequence_generator #(.WIDTH(W), .GAP(3), .IDLE_LEVEL(1'b1)) dut_gap (
    .clk(clk), .reset(reset), .data_in(g_data), .load_valid(g_valid),
    .load_ready(g_ready), .so(g_so), .so_valid(g_so_valid), .busy(g_busy), .done(g_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a payload bit
  always @(negedge clk) if (cyc >= 1) begin : mon
    exp_t e;
    chk("busy", busy, busy_at.exists(cyc) != 0);
    if (so_valid) begin
      if (sbq.size() == 0) chk("unexpected_bit", 1'b1, 1'b0);
      else begin
        e = sbq.pop_front();
        chk_i("bit_time", cyc, e.cyc);
        chk("so_bit", so, e.b);
        chk("done", done, e.d);
      end
      hist = {hist[1:0], so};
      if (hist == 3'b110) det_cnt++;
    end else begin
      chk("so_idle", so, 1'b0);
      chk("done_idle", done, 1'b0);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        chk("missing_bit", 1'b0, 1'b1);
        void'(sbq.pop_front());
      end
      hist = '0;
    end
  end

  // drive one cycle of stimulus for the edge ending this cycle and update the reference model
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int x = cyc + 1;
    chk("load_ready", load_ready, x >= next_ok);
    load_valid = v;
    data_in = d;
    reset = r;
    if (r) begin
      while (sbq.size() > 0 && sbq[$].cyc >= x) void'(sbq.pop_back());
      for (int c = x; c <= x + 2 * W; c++) busy_at.delete(c);
      next_ok = x + 1;
    end else if (v && x >= next_ok) begin
      for (int j = 1; j <= W; j++) begin
        sbq.push_back('{x + j - 1, d[W-j], 1'(j == W)});
        busy_at[x + j - 1] = 1'b1;
      end
      next_ok = x + W;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int det0, x0, p;
    logic [7:0] w;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    step(1'b1, 8'hD2, 1'b0);
    idle(10);
    for (int i = 0; i <= 8; i++) step(1'b1, (i < 8) ? 8'hA5 : 8'h3C, 1'b0);
    idle(10);
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
    idle(6);
    step(1'b1, 8'hF0, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h81, 1'b0);
    idle(10);
    step(1'b1, 8'hAA, 1'b1);
    idle(3);
    det0 = det_cnt;
    step(1'b1, 8'b01101100, 1'b0);
    idle(10);
    chk_i("detect110", det_cnt - det0, 2);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 60) == 0);
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    x0 = cyc + 1;
    g_valid = 1'b1;
    g_data = 8'hA5;
    for (int t = 0; t < 24; t++) begin
      step(1'b0, 8'h00, 1'b0);
      g_data = 8'h3C;
      if (t == 12) g_valid = 1'b0;
      chk_i("gap_time", cyc - x0, t);
      p = (t < 12) ? t : t - 12;
      w = (t < 12) ? 8'hA5 : 8'h3C;
      chk("gap_valid", g_so_valid, p < 8);
      chk("gap_so", g_so, (p < 8) ? w[7-p] : 1'b1);
      chk("gap_done", g_done, p == 7);
      chk("gap_busy", g_busy, p < 11);
      chk("gap_ready", g_ready, p >= 11);
    end
    idle(3);
    chk_i("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
